// File: rtl/seg_scan_alarm.sv
// Six-digit multiplexed 7-segment scanner with a countdown-zero alarm.
// The display walks digits 0..5 one slot at a time; the alarm FSM arms while
// the timer runs, rings a square-wave buzzer when the digits reach zero, and
// leaves ringing on a user acknowledge edge or after a fixed number of toggles.
module seg_scan_alarm #(
  parameter int SCAN_DIV     = 50000,
  parameter int BEEP_DIV     = 25000,
  parameter int RING_TOGGLES = 2000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_d5,
  input  logic [3:0] i_d4,
  input  logic [3:0] i_d3,
  input  logic [3:0] i_d2,
  input  logic [3:0] i_d1,
  input  logic [3:0] i_d0,
  input  logic       i_run,
  input  logic       i_alarm_ack,
  output logic [6:0] o_seg,
  output logic [5:0] o_an,
  output logic       o_dp,
  output logic       o_buzzer,
  output logic       o_alarm_active
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BEEP_DIV);
  localparam int TW = $clog2(RING_TOGGLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BEEP_DIV - 1);
  localparam logic [TW-1:0] TMAX = TW'(RING_TOGGLES);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RING} state_t;

  logic [PW-1:0] r_pre;
  logic [2:0]    r_idx;
  logic [6:0]    r_seg;
  logic [5:0]    r_an;
  logic          r_dp;
  logic          r_zero;
  logic          r_ack_q;
  logic [PW-1:0] r_dis;
  logic [BW-1:0] r_beep;
  logic [TW-1:0] r_tog;
  logic          r_buz;
  state_t        r_state;

  logic          w_wrap;
  logic [3:0]    w_digit;
  logic          w_ack_rise;
  logic          w_idle_cond;
  state_t        w_nxt;

  function automatic logic [6:0] f_dec(input logic [3:0] v);
    case (v)
      4'd0:    f_dec = 7'b1000000;
      4'd1:    f_dec = 7'b1111001;
      4'd2:    f_dec = 7'b0100100;
      4'd3:    f_dec = 7'b0110000;
      4'd4:    f_dec = 7'b0011001;
      4'd5:    f_dec = 7'b0010010;
      4'd6:    f_dec = 7'b0000010;
      4'd7:    f_dec = 7'b1111000;
      4'd8:    f_dec = 7'b0000000;
      4'd9:    f_dec = 7'b0010000;
      default: f_dec = 7'b1111111;
    endcase
  endfunction

  assign w_wrap      = (r_pre == PMAX);
  assign w_ack_rise  = i_alarm_ack & ~r_ack_q;
  assign w_idle_cond = ~i_run & ~r_zero;

  // Slot prescaler and digit index; the index moves on the prescaler wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre <= '0;
      r_idx <= 3'd0;
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap) r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    w_digit = i_d0;
    case (r_idx)
      3'd1:    w_digit = i_d1;
      3'd2:    w_digit = i_d2;
      3'd3:    w_digit = i_d3;
      3'd4:    w_digit = i_d4;
      3'd5:    w_digit = i_d5;
      default: w_digit = i_d0;
    endcase
  end

  // Registered display drive; digits are resampled every cycle so mid-slot
  // changes show up one cycle later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_an  <= 6'b111110;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(6'b000001 << r_idx);
      r_seg <= f_dec(w_digit);
      r_dp  <= ~((r_idx == 3'd2) || (r_idx == 3'd4));
    end
  end

  // Alarm next-state logic.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_run && !r_zero) w_nxt = S_ARMED;
      S_ARMED: begin
        if (r_zero)                          w_nxt = S_RING;
        else if (w_idle_cond && r_dis == PMAX) w_nxt = S_IDLE;
      end
      S_RING:  if (w_ack_rise || r_tog == TMAX) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, zero flag, ack history and the pause/disarm timer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_zero  <= 1'b0;
      r_ack_q <= 1'b0;
      r_dis   <= '0;
    end else begin
      r_state <= w_nxt;
      r_zero  <= (i_d5 == 4'd0) && (i_d4 == 4'd0) && (i_d3 == 4'd0) &&
                 (i_d2 == 4'd0) && (i_d1 == 4'd0) && (i_d0 == 4'd0);
      r_ack_q <= i_alarm_ack;
      if (r_state == S_ARMED && w_idle_cond) r_dis <= r_dis + 1'b1;
      else                                   r_dis <= '0;
    end
  end

  // Buzzer generator: counters start fresh on entry, output drops on exit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_beep <= '0;
      r_tog  <= '0;
      r_buz  <= 1'b0;
    end else if (w_nxt != S_RING || r_state != S_RING) begin
      r_beep <= '0;
      r_tog  <= '0;
      r_buz  <= 1'b0;
    end else if (r_beep == BMAX) begin
      r_beep <= '0;
      r_buz  <= ~r_buz;
      r_tog  <= r_tog + 1'b1;
    end else begin
      r_beep <= r_beep + 1'b1;
    end
  end

  assign o_seg          = r_seg;
  assign o_an           = r_an;
  assign o_dp           = r_dp;
  assign o_buzzer       = r_buz;
  assign o_alarm_active = (r_state == S_RING);
endmodule

// File: tb/tb_seg_scan_alarm.sv
// Bench for seg_scan_alarm: decode table, directed scan/alarm sequences and
// a randomized run against a cycle-count based reference model.
module tb_seg_scan_alarm;
  localparam int SD = 4;
  localparam int BD = 2;
  localparam int RT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dg [6];
  logic       run = 1'b0;
  logic       ack = 1'b0;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp, buz, act;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
  } vec_t;
  vec_t tbl [16];
  logic [5:0] walk [6];

  // reference model: edge count, alarm mode and cycles spent ringing
  int  n, m_st, m_rc, m_dis;
  bit  m_zf, m_ackp;
  logic [6:0] e_seg;
  logic [5:0] e_an;
  logic       e_dp;

  seg_scan_alarm #(.SCAN_DIV(SD), .BEEP_DIV(BD), .RING_TOGGLES(RT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_d5(dg[5]), .i_d4(dg[4]), .i_d3(dg[3]), .i_d2(dg[2]), .i_d1(dg[1]), .i_d0(dg[0]),
    .i_run(run), .i_alarm_ack(ack),
    .o_seg(seg), .o_an(an), .o_dp(dp), .o_buzzer(buz), .o_alarm_active(act)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40; 4'd1: return 7'h79; 4'd2: return 7'h24; 4'd3: return 7'h30;
      4'd4: return 7'h19; 4'd5: return 7'h12; 4'd6: return 7'h02; 4'd7: return 7'h78;
      4'd8: return 7'h00; 4'd9: return 7'h10; default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic set_all(input logic [23:0] v);
    for (int i = 0; i < 6; i++) dg[i] = v[4*i +: 4];
  endtask

  task automatic model_reset();
    n = 0; m_st = 0; m_rc = 0; m_dis = 0; m_zf = 0; m_ackp = 0;
    e_seg = 7'h7F; e_an = 6'b111110; e_dp = 1'b1;
  endtask

  task automatic chk_model();
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("alarm_active", act, (m_st == 2) ? 1 : 0);
    chk("buzzer", buz, (m_st == 2) ? (m_rc / BD) % 2 : 0);
  endtask

  // One clock: capture inputs, advance the model on the edge, compare after.
  task automatic tick();
    logic [3:0] cd [6];
    logic cr, ca;
    bit rise, allz;
    int idx;
    cd = dg; cr = run; ca = ack;
    @(posedge clk);
    n++;
    idx = ((n - 1) / SD) % 6;
    e_an  = ~(6'b000001 << idx);
    e_seg = ref_seg(cd[idx]);
    e_dp  = !(idx == 2 || idx == 4);
    allz = 1;
    for (int i = 0; i < 6; i++) if (cd[i] != 4'd0) allz = 0;
    rise = ca && !m_ackp;
    case (m_st)
      0: if (cr && !m_zf) begin m_st = 1; m_dis = 0; end
      1: begin
        if (m_zf) begin m_st = 2; m_rc = 0; end
        else if (!cr) begin m_dis++; if (m_dis == SD) m_st = 0; end
        else m_dis = 0;
      end
      default: begin
        m_rc++;
        if (rise || m_rc == BD * RT + 1) m_st = 0;
      end
    endcase
    m_zf = allz; m_ackp = ca;
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_an", an, 6'b111110);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_buz", buz, 0);
    chk("rst_act", act, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ntog;
    logic pb;
    tbl[0]  = '{4'd0,  7'b1000000}; tbl[1]  = '{4'd1,  7'b1111001};
    tbl[2]  = '{4'd2,  7'b0100100}; tbl[3]  = '{4'd3,  7'b0110000};
    tbl[4]  = '{4'd4,  7'b0011001}; tbl[5]  = '{4'd5,  7'b0010010};
    tbl[6]  = '{4'd6,  7'b0000010}; tbl[7]  = '{4'd7,  7'b1111000};
    tbl[8]  = '{4'd8,  7'b0000000}; tbl[9]  = '{4'd9,  7'b0010000};
    tbl[10] = '{4'd10, 7'b1111111}; tbl[11] = '{4'd11, 7'b1111111};
    tbl[12] = '{4'd12, 7'b1111111}; tbl[13] = '{4'd13, 7'b1111111};
    tbl[14] = '{4'd14, 7'b1111111}; tbl[15] = '{4'd15, 7'b1111111};
    walk[0] = 6'b111110; walk[1] = 6'b111101; walk[2] = 6'b111011;
    walk[3] = 6'b110111; walk[4] = 6'b101111; walk[5] = 6'b011111;

    // scan walk with digits 1..6, run low
    run = 0; ack = 0;
    set_all(24'h123456);
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("walk_an", an, walk[(k - 1) / 4]);
      chk("walk_dp", dp, ((k - 1) / 4 == 2 || (k - 1) / 4 == 4) ? 0 : 1);
      if (k == 1) chk("slot0_seg", seg, 7'b0000010);
    end

    // decode table: all digits carry the same value, so any slot shows it
    for (int i = 0; i < 16; i++) begin
      set_all({6{tbl[i].dig}});
      tick();
      chk("decode", seg, tbl[i].seg);
    end

    // blank digit on slot 0, then a mid-slot change
    set_all(24'h00000A);
    do_reset();
    tick();
    chk("blank_A", seg, 7'b1111111);
    dg[0] = 4'd0;
    tick();
    chk("midslot_0", seg, 7'b1000000);

    // countdown to zero, automatic timeout after RT toggles
    run = 1;
    set_all(24'h000001);
    do_reset();
    repeat (3) tick();
    dg[0] = 4'd0;
    tick();
    chk("ring_lat1", act, 0);
    tick();
    chk("ring_lat2", act, 1);
    ntog = 0; pb = buz;
    repeat (12) begin
      tick();
      if (buz !== pb) ntog++;
      pb = buz;
    end
    chk("toggles", ntog, RT);
    chk("still_ring", act, 1);
    tick();
    chk("timeout_act", act, 0);
    chk("timeout_buz", buz, 0);
    repeat (20) tick();
    chk("no_rering", act, 0);

    // acknowledge while ringing
    set_all(24'h000001);
    do_reset();
    repeat (3) tick();
    dg[0] = 4'd0;
    repeat (4) tick();
    chk("pre_ack", act, 1);
    ack = 1;
    tick();
    ack = 0;
    tick();
    chk("ack_act", act, 0);
    chk("ack_buz", buz, 0);
    repeat (20) tick();
    chk("ack_no_rering", act, 0);

    // ack rising on the entry edge is ignored
    set_all(24'h000001);
    do_reset();
    repeat (3) tick();
    dg[0] = 4'd0;
    tick();
    ack = 1;
    tick();
    chk("entry_ack", act, 1);
    tick();
    chk("held_ack", act, 1);
    ack = 0;
    repeat (15) tick();

    // short pause keeps the alarm armed
    set_all(24'h000001);
    do_reset();
    repeat (2) tick();
    run = 0;
    repeat (2) tick();
    set_all(24'h000000);
    repeat (2) tick();
    chk("pause_ring", act, 1);
    repeat (15) tick();

    // full-period pause disarms
    run = 1;
    set_all(24'h000001);
    do_reset();
    repeat (2) tick();
    run = 0;
    repeat (4) tick();
    set_all(24'h000000);
    repeat (5) tick();
    chk("disarm", act, 0);

    // asynchronous reset mid-ringing
    run = 1;
    set_all(24'h000001);
    do_reset();
    repeat (3) tick();
    dg[0] = 4'd0;
    repeat (5) tick();
    chk("pre_rst_buz", buz, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_buz", buz, 0);
    chk("async_act", act, 0);
    chk("async_an", an, 6'b111110);
    chk("async_seg", seg, 7'h7F);
    do_reset();

    // zero digits from reset with run low never ring
    run = 0;
    set_all(24'h000000);
    do_reset();
    repeat (100) begin
      tick();
      chk("zero_idle", act, 0);
    end

    // randomized traffic against the model
    run = 1;
    set_all(24'h000321);
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 7))
        0: set_all(24'h000000);
        1: set_all(24'($urandom()));
        2: dg[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) run = ~run;
      ack = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
